// File: rtl/id_stage_pipe_if.sv
// ID stage boundary bundle: IF request, write-back port, EX handshake and ID/EX register outputs.
// master: the decode stage itself; slave: the surrounding pipeline that drives it.
// XLEN/RAW must match the id_stage_pipe instance the bundle is attached to.
interface id_stage_pipe_if #(
    parameter int XLEN = 32,
    parameter int RAW  = 5
);
    logic            if_valid;
    logic [31:0]     if_instr;
    logic [31:0]     if_pc;
    logic            id_ready;
    logic            wb_we;
    logic [RAW-1:0]  wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            ex_ready;
    logic            flush;
    logic            ex_valid;
    logic [31:0]     ex_pc;
    logic [5:0]      ex_op;
    logic [5:0]      ex_funct;
    logic [4:0]      ex_shamt;
    logic [XLEN-1:0] ex_rs_data;
    logic [XLEN-1:0] ex_rt_data;
    logic [XLEN-1:0] ex_imm;
    logic [25:0]     ex_target;
    logic [RAW-1:0]  ex_dst;
    logic            ex_regwrite;
    logic            ex_memread;
    logic            ex_memwrite;

    modport master (
        input  if_valid, if_instr, if_pc, wb_we, wb_addr, wb_data, ex_ready, flush,
        output id_ready, ex_valid, ex_pc, ex_op, ex_funct, ex_shamt, ex_rs_data,
               ex_rt_data, ex_imm, ex_target, ex_dst, ex_regwrite, ex_memread, ex_memwrite
    );

    modport slave (
        output if_valid, if_instr, if_pc, wb_we, wb_addr, wb_data, ex_ready, flush,
        input  id_ready, ex_valid, ex_pc, ex_op, ex_funct, ex_shamt, ex_rs_data,
               ex_rt_data, ex_imm, ex_target, ex_dst, ex_regwrite, ex_memread, ex_memwrite
    );
endinterface

// File: rtl/id_stage_pipe.sv
// Decode stage: decodes IF word, reads bypassed register file, detects load-use, fills ID/EX register.
// Latency: 1 cycle from accept (if_valid && id_ready) to ex_valid.
// Backpressure: ex_ready low holds ID/EX and drops id_ready; load-use inserts one bubble; flush kills ID/EX.
module id_stage_pipe #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int RAW      = $clog2(NUM_REGS),
    parameter int LINK_REG = 31
) (
    input  logic               clk,
    input  logic               reset,
    id_stage_pipe_if.master    bus
);
    typedef struct packed {
        logic [31:0]     pc;
        logic [5:0]      op;
        logic [5:0]      funct;
        logic [4:0]      shamt;
        logic [XLEN-1:0] rs_data;
        logic [XLEN-1:0] rt_data;
        logic [XLEN-1:0] imm;
        logic [25:0]     target;
        logic [RAW-1:0]  dst;
        logic            regwrite;
        logic            memread;
        logic            memwrite;
    } ex_fields_t;

    localparam logic [RAW-1:0] LINK_ADDR = RAW'(LINK_REG);

    logic [XLEN-1:0] rf [NUM_REGS];
    ex_fields_t      dec;
    ex_fields_t      ex_reg;
    logic            ex_live;
    logic [5:0]      op;
    logic [15:0]     imm16;
    logic [RAW-1:0]  rs;
    logic [RAW-1:0]  rt;
    logic [RAW-1:0]  rd;
    logic            rs_used;
    logic            rt_used;
    logic            stall;

    assign op    = bus.if_instr[31:26];
    assign imm16 = bus.if_instr[15:0];
    assign rs    = bus.if_instr[21 +: RAW];
    assign rt    = bus.if_instr[16 +: RAW];
    assign rd    = bus.if_instr[11 +: RAW];

    // Register file write port; r0 is never written so it stays zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
        end else if (bus.wb_we && bus.wb_addr != '0) begin
            rf[bus.wb_addr] <= bus.wb_data;
        end
    end

    // Decode the presented word into the ID/EX field set, including bypassed operand reads.
    always_comb begin
        dec          = '0;
        dec.pc       = bus.if_pc;
        dec.op       = op;
        dec.funct    = bus.if_instr[5:0];
        dec.shamt    = bus.if_instr[10:6];
        dec.target   = bus.if_instr[25:0];

        dec.rs_data = rf[rs];
        if (bus.wb_we && bus.wb_addr == rs) dec.rs_data = bus.wb_data;
        if (rs == '0) dec.rs_data = '0;
        dec.rt_data = rf[rt];
        if (bus.wb_we && bus.wb_addr == rt) dec.rt_data = bus.wb_data;
        if (rt == '0) dec.rt_data = '0;

        case (op)
            6'h00: begin
                dec.dst      = rd;
                dec.regwrite = (bus.if_instr[5:0] != 6'h08);
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                dec.dst      = rt;
                dec.regwrite = 1'b1;
            end
            6'h23: begin
                dec.dst      = rt;
                dec.regwrite = 1'b1;
                dec.memread  = 1'b1;
            end
            6'h2B:   dec.memwrite = 1'b1;
            6'h03: begin
                dec.dst      = LINK_ADDR;
                dec.regwrite = 1'b1;
            end
            default: ;
        endcase

        case (op)
            6'h0C, 6'h0D, 6'h0E: dec.imm = XLEN'(imm16);
            6'h0F:               dec.imm = XLEN'({imm16, 16'h0000});
            default:             dec.imm = XLEN'($signed(imm16));
        endcase
    end

    // Operand usage and load-use detection against the load sitting in ID/EX.
    always_comb begin
        rs_used = !(op inside {6'h02, 6'h03, 6'h0F});
        rt_used = op inside {6'h00, 6'h2B, 6'h04, 6'h05};
        stall   = bus.if_valid && ex_live && ex_reg.memread && ex_reg.dst != '0 &&
                  ((rs_used && ex_reg.dst == rs) || (rt_used && ex_reg.dst == rt));
    end

    assign bus.id_ready = !stall && (!ex_live || bus.ex_ready);

    // ID/EX register: flush, then EX hold, then bubble, then load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_live <= 1'b0;
            ex_reg  <= '0;
        end else if (bus.flush) begin
            ex_live <= 1'b0;
        end else if (ex_live && !bus.ex_ready) begin
            ex_live <= 1'b1;
        end else if (stall) begin
            ex_live <= 1'b0;
        end else if (bus.if_valid) begin
            ex_live <= 1'b1;
            ex_reg  <= dec;
        end else begin
            ex_live <= 1'b0;
        end
    end

    assign bus.ex_valid    = ex_live;
    assign bus.ex_pc       = ex_reg.pc;
    assign bus.ex_op       = ex_reg.op;
    assign bus.ex_funct    = ex_reg.funct;
    assign bus.ex_shamt    = ex_reg.shamt;
    assign bus.ex_rs_data  = ex_reg.rs_data;
    assign bus.ex_rt_data  = ex_reg.rt_data;
    assign bus.ex_imm      = ex_reg.imm;
    assign bus.ex_target   = ex_reg.target;
    assign bus.ex_dst      = ex_reg.dst;
    assign bus.ex_regwrite = ex_reg.regwrite;
    assign bus.ex_memread  = ex_reg.memread;
    assign bus.ex_memwrite = ex_reg.memwrite;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: a 32-bit/32-register instance and a 16-bit/8-register instance
// share one stimulus stream; both are compared every cycle against a behavioural model,
// with directed sequences for write/read, bypass, immediates, load-use, backpressure and reset.
module tb_id_stage_pipe;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    id_stage_pipe_if #(.XLEN(32), .RAW(5)) b0 ();
    id_stage_pipe_if #(.XLEN(16), .RAW(3)) b1 ();

    id_stage_pipe #(.XLEN(32), .NUM_REGS(32), .LINK_REG(31)) dut0 (.clk(clk), .reset(reset), .bus(b0));
    id_stage_pipe #(.XLEN(16), .NUM_REGS(8),  .LINK_REG(7))  dut1 (.clk(clk), .reset(reset), .bus(b1));

    typedef struct {
        bit          vld, known, rw, mr, mw, ru, tu;
        logic [31:0] pc, a, b, imm;
        logic [5:0]  op, fn;
        logic [4:0]  sh;
        logic [25:0] tg;
        int          dst, rsi, rti;
    } mex_t;

    mex_t        m [2];
    logic [31:0] m_rf [2][32];

    logic        s_if_valid, s_wb_we, s_ex_ready, s_flush;
    logic [31:0] s_instr, s_pc, s_wb_data;
    logic [4:0]  s_wb_addr;
    logic [31:0] pc_ctr = 32'h0000_1000;
    logic        last_rdy0;
    int          n_checks = 0;
    int          n_fail = 0;

    logic [5:0] op_tab [16] = '{6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
                                6'h0E, 6'h0F, 6'h23, 6'h23, 6'h2B, 6'h03, 6'h04, 6'h05};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    function automatic int nr(input int c);    return (c == 0) ? 32 : 8;  endfunction
    function automatic int lk(input int c);    return (c == 0) ? 31 : 7;  endfunction
    function automatic longint msk(input int c);
        return (c == 0) ? 64'hFFFF_FFFF : 64'hFFFF;
    endfunction
    function automatic string nm(input int c, input string s);
        return $sformatf("c%0d_%s", c, s);
    endfunction

    function automatic logic [31:0] read_reg(input int c, input int a);
        if (a == 0) return 32'h0;
        if (s_wb_we && (int'(s_wb_addr) % nr(c)) == a) return 32'(longint'(s_wb_data) & msk(c));
        return m_rf[c][a];
    endfunction

    // Expected ID/EX contents if the presented word were loaded now.
    function automatic mex_t predict(input int c);
        mex_t   p;
        int     n = nr(c);
        int     rdi;
        longint i16, sv;
        p       = '{default: 0};
        p.vld   = 1'b1;
        p.known = 1'b1;
        p.pc    = s_pc;
        p.op    = s_instr[31:26];
        p.fn    = s_instr[5:0];
        p.sh    = s_instr[10:6];
        p.tg    = s_instr[25:0];
        p.rsi   = int'(s_instr[25:21]) % n;
        p.rti   = int'(s_instr[20:16]) % n;
        rdi     = int'(s_instr[15:11]) % n;
        p.a     = read_reg(c, p.rsi);
        p.b     = read_reg(c, p.rti);
        if (p.op == 6'h00) begin
            p.dst = rdi; p.rw = (p.fn != 6'h08);
        end else if (p.op inside {[6'h08:6'h0F]}) begin
            p.dst = p.rti; p.rw = 1'b1;
        end else if (p.op == 6'h23) begin
            p.dst = p.rti; p.rw = 1'b1; p.mr = 1'b1;
        end else if (p.op == 6'h2B) begin
            p.mw = 1'b1;
        end else if (p.op == 6'h03) begin
            p.dst = lk(c); p.rw = 1'b1;
        end
        i16 = longint'(s_instr[15:0]);
        if (p.op inside {6'h0C, 6'h0D, 6'h0E}) sv = i16;
        else if (p.op == 6'h0F)                sv = i16 * 65536;
        else                                   sv = (i16 >= 32768) ? i16 - 65536 : i16;
        p.imm = 32'(sv & msk(c));
        p.ru  = !(p.op inside {6'h02, 6'h03, 6'h0F});
        p.tu  = p.op inside {6'h00, 6'h2B, 6'h04, 6'h05};
        return p;
    endfunction

    function automatic bit exp_stall(input int c, input mex_t p);
        return s_if_valid && m[c].vld && m[c].mr && m[c].dst != 0 &&
               ((p.ru && m[c].dst == p.rsi) || (p.tu && m[c].dst == p.rti));
    endfunction

    task automatic model_clear(input int c);
        m[c]       = '{default: 0};
        m[c].known = 1'b1;
        for (int a = 0; a < 32; a++) m_rf[c][a] = 32'h0;
    endtask

    task automatic model_clock(input int c);
        mex_t p  = predict(c);
        bit   st = exp_stall(c, p);
        int   wa = int'(s_wb_addr) % nr(c);
        if (reset) begin
            model_clear(c);
            return;
        end
        if (s_wb_we && wa != 0) m_rf[c][wa] = 32'(longint'(s_wb_data) & msk(c));
        if (s_flush) begin
            m[c].vld = 1'b0; m[c].known = 1'b0;
        end else if (m[c].vld && !s_ex_ready) begin
            m[c].vld = 1'b1;
        end else if (st || !s_if_valid) begin
            m[c].vld = 1'b0; m[c].known = 1'b0;
        end else begin
            m[c] = p;
        end
    endtask

    task automatic compare(input int c);
        mex_t        p = predict(c);
        logic        o_rdy, o_vld, o_rw, o_mr, o_mw;
        logic [31:0] o_pc, o_a, o_b, o_imm, o_dst;
        logic [5:0]  o_op, o_fn;
        logic [4:0]  o_sh;
        logic [25:0] o_tg;
        if (c == 0) begin
            o_rdy = b0.id_ready; o_vld = b0.ex_valid; o_pc = b0.ex_pc; o_op = b0.ex_op;
            o_fn = b0.ex_funct; o_sh = b0.ex_shamt; o_a = b0.ex_rs_data; o_b = b0.ex_rt_data;
            o_imm = b0.ex_imm; o_tg = b0.ex_target; o_dst = 32'(b0.ex_dst);
            o_rw = b0.ex_regwrite; o_mr = b0.ex_memread; o_mw = b0.ex_memwrite;
        end else begin
            o_rdy = b1.id_ready; o_vld = b1.ex_valid; o_pc = b1.ex_pc; o_op = b1.ex_op;
            o_fn = b1.ex_funct; o_sh = b1.ex_shamt; o_a = 32'(b1.ex_rs_data); o_b = 32'(b1.ex_rt_data);
            o_imm = 32'(b1.ex_imm); o_tg = b1.ex_target; o_dst = 32'(b1.ex_dst);
            o_rw = b1.ex_regwrite; o_mr = b1.ex_memread; o_mw = b1.ex_memwrite;
        end
        check_eq(nm(c, "id_ready"), 32'(o_rdy), 32'(!exp_stall(c, p) && (!m[c].vld || s_ex_ready)));
        check_eq(nm(c, "ex_valid"), 32'(o_vld), 32'(m[c].vld));
        if (m[c].known) begin
            check_eq(nm(c, "pc"), o_pc, m[c].pc);
            check_eq(nm(c, "op"), 32'(o_op), 32'(m[c].op));
            check_eq(nm(c, "funct"), 32'(o_fn), 32'(m[c].fn));
            check_eq(nm(c, "shamt"), 32'(o_sh), 32'(m[c].sh));
            check_eq(nm(c, "target"), 32'(o_tg), 32'(m[c].tg));
            check_eq(nm(c, "rs_data"), o_a, m[c].a);
            check_eq(nm(c, "rt_data"), o_b, m[c].b);
            check_eq(nm(c, "imm"), o_imm, m[c].imm);
            check_eq(nm(c, "regwrite"), 32'(o_rw), 32'(m[c].rw));
            check_eq(nm(c, "memread"), 32'(o_mr), 32'(m[c].mr));
            check_eq(nm(c, "memwrite"), 32'(o_mw), 32'(m[c].mw));
            if (m[c].op == 6'h00 || m[c].rw) check_eq(nm(c, "dst"), o_dst, 32'(m[c].dst));
        end
    endtask

    // One clock: drive inputs, compare against model, advance model, move past the edge.
    task automatic step();
        b0.if_valid = s_if_valid; b0.if_instr = s_instr; b0.if_pc = s_pc;
        b0.wb_we = s_wb_we; b0.wb_addr = s_wb_addr; b0.wb_data = s_wb_data;
        b0.ex_ready = s_ex_ready; b0.flush = s_flush;
        b1.if_valid = s_if_valid; b1.if_instr = s_instr; b1.if_pc = s_pc;
        b1.wb_we = s_wb_we; b1.wb_addr = s_wb_addr[2:0]; b1.wb_data = s_wb_data[15:0];
        b1.ex_ready = s_ex_ready; b1.flush = s_flush;
        if (reset) begin
            model_clear(0);
            model_clear(1);
        end
        #1;
        last_rdy0 = b0.id_ready;
        compare(0);
        compare(1);
        model_clock(0);
        model_clock(1);
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input bit r, input bit iv, input logic [31:0] ins, input bit we,
                         input logic [4:0] wa, input logic [31:0] wd, input bit er, input bit fl);
        reset = r; s_if_valid = iv; s_instr = ins; s_wb_we = we; s_wb_addr = wa;
        s_wb_data = wd; s_ex_ready = er; s_flush = fl; s_pc = pc_ctr;
        pc_ctr = pc_ctr + 32'd4;
        step();
    endtask

    function automatic logic [4:0] rreg();
        return ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [5:0]  op;
        logic [31:0] w;
        op = op_tab[$urandom_range(0, 15)];
        if ($urandom_range(0, 9) == 0) op = 6'($urandom);
        w = {op, rreg(), rreg(), 16'($urandom)};
        if (op == 6'h00) begin
            w[15:11] = rreg();
            if ($urandom_range(0, 5) == 0) w[5:0] = 6'h08;
        end
        return w;
    endfunction

    logic [31:0] hold_pc;
    int          rst_left = 0;

    initial begin
        s_if_valid = 0; s_instr = 0; s_pc = 0; s_wb_we = 0; s_wb_addr = 0;
        s_wb_data = 0; s_ex_ready = 1; s_flush = 0;
        model_clear(0);
        model_clear(1);
        reset = 1'b1;
        @(negedge clk);
        #1;
        drive(1, 0, 32'h0, 0, 0, 32'h0, 1, 0);

        // Register write then read through a decoded addu r3,r5,r0.
        drive(0, 0, 32'h0, 1, 5'd5, 32'h1234ABCD, 1, 0);
        drive(0, 1, 32'h00A01821, 0, 0, 32'h0, 1, 0);
        check_eq("wr_rs", b0.ex_rs_data, 32'h1234ABCD);
        check_eq("wr_rt", b0.ex_rt_data, 32'h0);
        check_eq("wr_dst", 32'(b0.ex_dst), 32'd3);
        check_eq("wr_regwrite", 32'(b0.ex_regwrite), 32'd1);
        check_eq("wr_rs16", 32'(b1.ex_rs_data), 32'h0000ABCD);
        drive(0, 1, 32'h00001821, 1, 5'd0, 32'hFFFFFFFF, 1, 0);
        check_eq("r0_bypass", b0.ex_rs_data, 32'h0);
        drive(0, 1, 32'h00001821, 0, 0, 32'h0, 1, 0);
        check_eq("r0_read", b0.ex_rs_data, 32'h0);

        // Same-cycle bypass and immediate forms.
        drive(0, 1, 32'h20E8FFFF, 1, 5'd7, 32'h55, 1, 0);
        check_eq("byp_rs", b0.ex_rs_data, 32'h55);
        check_eq("byp_imm", b0.ex_imm, 32'hFFFFFFFF);
        check_eq("byp_rs16", 32'(b1.ex_rs_data), 32'h55);
        check_eq("byp_imm16", 32'(b1.ex_imm), 32'h0000FFFF);
        drive(0, 1, 32'h34098000, 0, 0, 32'h0, 1, 0);
        check_eq("ori_imm", b0.ex_imm, 32'h00008000);
        drive(0, 1, 32'h3C0A1234, 0, 0, 32'h0, 1, 0);
        check_eq("lui_imm", b0.ex_imm, 32'h12340000);
        check_eq("lui_imm16", 32'(b1.ex_imm), 32'h0);
        drive(0, 1, 32'h0C000010, 0, 0, 32'h0, 1, 0);
        check_eq("jal_dst", 32'(b0.ex_dst), 32'd31);
        check_eq("jal_dst16", 32'(b1.ex_dst), 32'd7);

        // Load-use: exactly one bubble, then the dependent add enters.
        drive(0, 1, 32'h8C220000, 0, 0, 32'h0, 1, 0);
        check_eq("lw_memread", 32'(b0.ex_memread), 32'd1);
        drive(0, 1, 32'h00432020, 0, 0, 32'h0, 1, 0);
        check_eq("lu_rdy_low", 32'(last_rdy0), 32'd0);
        check_eq("lu_bubble", 32'(b0.ex_valid), 32'd0);
        drive(0, 1, 32'h00432020, 0, 0, 32'h0, 1, 0);
        check_eq("lu_rdy_back", 32'(last_rdy0), 32'd1);
        check_eq("lu_add_vld", 32'(b0.ex_valid), 32'd1);
        check_eq("lu_add_dst", 32'(b0.ex_dst), 32'd4);
        drive(0, 1, 32'h8C220000, 0, 0, 32'h0, 1, 0);
        drive(0, 1, 32'hACC50000, 0, 0, 32'h0, 1, 0);
        check_eq("sw_nostall", 32'(last_rdy0), 32'd1);
        check_eq("sw_memwrite", 32'(b0.ex_memwrite), 32'd1);

        // Backpressure holds ID/EX; flush wins over hold.
        drive(0, 1, 32'h00A01821, 0, 0, 32'h0, 1, 0);
        hold_pc = s_pc;
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 32'h20E8FFFF, 0, 0, 32'h0, 0, 0);
            check_eq("bp_rdy", 32'(last_rdy0), 32'd0);
            check_eq("bp_pc", b0.ex_pc, hold_pc);
            check_eq("bp_vld", 32'(b0.ex_valid), 32'd1);
        end
        drive(0, 1, 32'h20E8FFFF, 0, 0, 32'h0, 0, 1);
        check_eq("flush_vld", 32'(b0.ex_valid), 32'd0);

        // Reset mid-traffic, including while a load-use stall is pending.
        drive(0, 1, 32'h8C220000, 0, 0, 32'h0, 1, 0);
        drive(1, 1, 32'h00432020, 0, 0, 32'h0, 1, 0);
        drive(1, 1, 32'h00432020, 0, 0, 32'h0, 1, 0);
        check_eq("rst_vld", 32'(b0.ex_valid), 32'd0);
        check_eq("rst_rdy", 32'(last_rdy0), 32'd1);
        drive(0, 1, 32'h00A01821, 0, 0, 32'h0, 1, 0);
        check_eq("rst_rf", b0.ex_rs_data, 32'h0);
        check_eq("rst_nobubble", 32'(last_rdy0), 32'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if (rst_left == 0 && $urandom_range(0, 299) == 0) rst_left = 2;
            drive(rst_left > 0, $urandom_range(0, 9) < 8, rand_instr(),
                  $urandom_range(0, 1) == 1, rreg(), $urandom,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
            if (rst_left > 0) rst_left--;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
